// File: rtl/ddram_arbiter.sv
// Two-client arbiter for the single Avalon-MM style DDRAM port.
// Latches the winning request at grant, holds it through BUSY and routes read beats back to the owner.
module ddram_arbiter #(
  parameter bit RR_MODE   = 1'b0,
  parameter int MAX_BURST = 8
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,

  input  logic        cA_req,
  input  logic        cA_we,
  input  logic [28:0] cA_addr,
  input  logic [7:0]  cA_burst,
  input  logic [63:0] cA_din,
  input  logic [7:0]  cA_be,
  output logic        cA_ack,
  output logic        cA_valid,
  output logic [63:0] cA_dout,

  input  logic        cB_req,
  input  logic        cB_we,
  input  logic [28:0] cB_addr,
  input  logic [7:0]  cB_burst,
  input  logic [63:0] cB_din,
  input  logic [7:0]  cB_be,
  output logic        cB_ack,
  output logic        cB_valid,
  output logic [63:0] cB_dout,

  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  output logic        DDRAM_RD,
  output logic        DDRAM_WE,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RDWAIT} state_t;
  typedef enum logic {CL_A, CL_B} client_t;

  state_t      state, state_next;
  client_t     owner, rr_last, grant_to;
  logic [7:0]  beats_left;
  logic        grant, pick_b, sel_we, beat, last_beat;
  logic [28:0] sel_addr;
  logic [7:0]  sel_burst, sel_be, burst_clamped;
  logic [63:0] sel_din;

  // Winner selection: A unless only B asks, or round-robin says A went last.
  always_comb begin
    // NOTE: every combinational output is assigned a default first so no latch is inferred.
    grant    = cA_req | cB_req;
    pick_b   = cB_req & (~cA_req | (RR_MODE & (rr_last == CL_A)));
    grant_to = pick_b ? CL_B : CL_A;
    sel_we    = pick_b ? cB_we    : cA_we;
    sel_addr  = pick_b ? cB_addr  : cA_addr;
    sel_burst = pick_b ? cB_burst : cA_burst;
    sel_din   = pick_b ? cB_din   : cA_din;
    sel_be    = pick_b ? cB_be    : cA_be;
    if (sel_burst == 8'd0)       burst_clamped = 8'd1;
    else if (sel_burst > MAX_B)  burst_clamped = MAX_B;
    else                         burst_clamped = sel_burst;
  end

  always_comb begin
    state_next = state;
    beat       = (state == S_RDWAIT) && DDRAM_DOUT_READY;
    last_beat  = beat && (beats_left == 8'd1);
    unique case (state)
      S_IDLE:   if (grant) state_next = S_CMD;
      S_CMD:    if (!DDRAM_BUSY) state_next = DDRAM_WE ? S_IDLE : S_RDWAIT;
      S_RDWAIT: if (last_beat) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      owner          <= CL_A;
      rr_last        <= CL_B;
      beats_left     <= '0;
      DDRAM_RD       <= 1'b0;
      DDRAM_WE       <= 1'b0;
      DDRAM_BURSTCNT <= 8'd1;
      DDRAM_ADDR     <= '0;
      DDRAM_DIN      <= '0;
      DDRAM_BE       <= '0;
      cA_ack         <= 1'b0;
      cB_ack         <= 1'b0;
      cA_valid       <= 1'b0;
      cB_valid       <= 1'b0;
      cA_dout        <= '0;
      cB_dout        <= '0;
    end else begin
      cA_ack   <= 1'b0;
      cB_ack   <= 1'b0;
      cA_valid <= 1'b0;
      cB_valid <= 1'b0;
      unique case (state)
        S_IDLE: if (grant) begin
          owner          <= grant_to;
          rr_last        <= grant_to;
          DDRAM_ADDR     <= sel_addr;
          DDRAM_DIN      <= sel_din;
          DDRAM_WE       <= sel_we;
          DDRAM_RD       <= ~sel_we;
          DDRAM_BE       <= sel_we ? sel_be : 8'hFF;
          DDRAM_BURSTCNT <= sel_we ? 8'd1 : burst_clamped;
        end
        S_CMD: if (!DDRAM_BUSY) begin
          DDRAM_RD <= 1'b0;
          DDRAM_WE <= 1'b0;
          if (DDRAM_WE) begin
            if (owner == CL_B) cB_ack <= 1'b1;
            else               cA_ack <= 1'b1;
          end else begin
            beats_left <= DDRAM_BURSTCNT;
          end
        end
        S_RDWAIT: if (beat) begin
          beats_left <= beats_left - 8'd1;
          if (owner == CL_B) begin
            cB_dout  <= DDRAM_DOUT;
            cB_valid <= 1'b1;
            cB_ack   <= last_beat;
          end else begin
            cA_dout  <= DDRAM_DOUT;
            cA_valid <= 1'b1;
            cA_ack   <= last_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Scoreboard bench for ddram_arbiter: dut0 uses fixed priority, dut1 round-robin.
// A bus responder plays the DDRAM side; a monitor pops expected client events.
module tb_ddram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_a [2];
  logic        req_b [2];
  logic        a_we = 1'b0, b_we = 1'b0;
  logic [28:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_burst = '0, b_burst = '0, a_be = '0, b_be = '0;
  logic [63:0] a_din = '0, b_din = '0;
  logic        busy = 1'b0, dout_ready = 1'b0;
  logic [63:0] ddr_dout = '0;

  logic        a_ack [2], a_valid [2], b_ack [2], b_valid [2];
  logic [63:0] a_dout [2], b_dout [2], din [2];
  logic [7:0]  burstcnt [2], be [2];
  logic [28:0] addr [2];
  logic        rd [2], we [2];

  ddram_arbiter #(.RR_MODE(1'b0), .MAX_BURST(8)) dut0 (
    .DDRAM_CLK(clk), .reset(rst),
    .cA_req(req_a[0]), .cA_we(a_we), .cA_addr(a_addr), .cA_burst(a_burst), .cA_din(a_din), .cA_be(a_be),
    .cA_ack(a_ack[0]), .cA_valid(a_valid[0]), .cA_dout(a_dout[0]),
    .cB_req(req_b[0]), .cB_we(b_we), .cB_addr(b_addr), .cB_burst(b_burst), .cB_din(b_din), .cB_be(b_be),
    .cB_ack(b_ack[0]), .cB_valid(b_valid[0]), .cB_dout(b_dout[0]),
    .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(burstcnt[0]), .DDRAM_ADDR(addr[0]), .DDRAM_RD(rd[0]),
    .DDRAM_WE(we[0]), .DDRAM_DIN(din[0]), .DDRAM_BE(be[0]), .DDRAM_DOUT(ddr_dout),
    .DDRAM_DOUT_READY(dout_ready)
  );

  ddram_arbiter #(.RR_MODE(1'b1), .MAX_BURST(8)) dut1 (
    .DDRAM_CLK(clk), .reset(rst),
    .cA_req(req_a[1]), .cA_we(a_we), .cA_addr(a_addr), .cA_burst(a_burst), .cA_din(a_din), .cA_be(a_be),
    .cA_ack(a_ack[1]), .cA_valid(a_valid[1]), .cA_dout(a_dout[1]),
    .cB_req(req_b[1]), .cB_we(b_we), .cB_addr(b_addr), .cB_burst(b_burst), .cB_din(b_din), .cB_be(b_be),
    .cB_ack(b_ack[1]), .cB_valid(b_valid[1]), .cB_dout(b_dout[1]),
    .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(burstcnt[1]), .DDRAM_ADDR(addr[1]), .DDRAM_RD(rd[1]),
    .DDRAM_WE(we[1]), .DDRAM_DIN(din[1]), .DDRAM_BE(be[1]), .DDRAM_DOUT(ddr_dout),
    .DDRAM_DOUT_READY(dout_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          d;
    logic        c;
    logic        v;
    logic        k;
    logic [63:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] model_dout [2][2];

  function automatic logic [63:0] beat_data(input logic [28:0] ad, input int i);
    return {3'b101, ad, 24'h5A5A00, 8'(i)};
  endfunction

  function automatic int clamp(input logic [7:0] b);
    if (b == 8'd0) return 1;
    if (b > 8'd8)  return 8;
    return int'(b);
  endfunction

  task automatic expect_op(input int d, input logic c, input logic w,
                           input logic [28:0] ad, input logic [7:0] bu);
    int n;
    if (w) begin
      sb.push_back('{d, c, 1'b0, 1'b1, 64'h0});
    end else begin
      n = clamp(bu);
      for (int i = 0; i < n; i++) sb.push_back('{d, c, 1'b1, (i == n - 1), beat_data(ad, i)});
      model_dout[d][c] = beat_data(ad, n - 1);
    end
  endtask

  task automatic client_op(input int d, input logic c, input logic w, input logic [28:0] ad,
                           input logic [7:0] bu, input logic [63:0] di, input logic [7:0] bm);
    logic seen;
    seen = 1'b0;
    if (c) begin
      b_we = w; b_addr = ad; b_burst = bu; b_din = di; b_be = bm; req_b[d] = 1'b1;
    end else begin
      a_we = w; a_addr = ad; a_burst = bu; a_din = di; a_be = bm; req_a[d] = 1'b1;
    end
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (c ? b_ack[d] : a_ack[d]) begin
        seen = 1'b1;
        break;
      end
    end
    if (c) req_b[d] = 1'b0;
    else   req_a[d] = 1'b0;
    if (!seen) check(c ? "b_ack_timeout" : "a_ack_timeout", c ? b_ack[d] : a_ack[d], 1);
  endtask

  // Monitor: every valid/ack pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          logic v, k;
          logic [63:0] dat;
          exp_t e;
          v   = c[0] ? b_valid[d] : a_valid[d];
          k   = c[0] ? b_ack[d]   : a_ack[d];
          dat = c[0] ? b_dout[d]  : a_dout[d];
          if (v || k) begin
            if (sb.size() == 0) begin
              check("sb_unexpected", {62'd0, v, k}, 64'd0);
            end else begin
              e = sb.pop_front();
              check("sb_dut", d, e.d);
              check("sb_client", c, e.c);
              check("sb_valid", v, e.v);
              check("sb_ack", k, e.k);
              if (e.v) check("sb_data", dat, e.data);
            end
          end
        end
      end
    end
  end

  // DDRAM-side responder: stalls new commands for busy_n cycles, returns read beats, emits strays.
  int          act = 0;
  int          busy_n = 0;
  int          beat_limit = 64;
  int          stray_req = 0;
  int          stray_done = 0;
  logic [7:0]  last_burstcnt = '0;
  logic [28:0] r_base;
  logic        r_rd;
  int          r_n;

  initial forever begin
    @(negedge clk);
    if (!rst && (rd[act] || we[act])) begin
      r_base        = addr[act];
      r_rd          = rd[act];
      r_n           = int'(burstcnt[act]);
      last_burstcnt = burstcnt[act];
      busy          = (busy_n > 0);
      for (int i = 0; i < busy_n; i++) begin
        @(negedge clk);
        check("cmd_hold_addr", addr[act], r_base);
        check("cmd_hold_strobe", rd[act] | we[act], 1);
        if (i == busy_n - 1) busy = 1'b0;
      end
      if (r_rd) begin
        for (int i = 0; i < r_n && i < beat_limit && i < 32; i++) begin
          @(negedge clk);
          dout_ready = 1'b1;
          ddr_dout   = beat_data(r_base, i);
          @(negedge clk);
          dout_ready = 1'b0;
        end
      end
    end else if (stray_done < stray_req) begin
      stray_done++;
      dout_ready = 1'b1;
      ddr_dout   = 64'hDEAD_0000_0000_0000 | 64'(stray_done);
      @(negedge clk);
      dout_ready = 1'b0;
    end
  end

  int rd_cnt = 0;
  int be_bad = 0;
  always @(negedge clk) begin
    if (!rst && rd[act]) begin
      rd_cnt++;
      if (be[act] != 8'hFF) be_bad++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int rd0, be0;
    logic [28:0] t1_addr;
    for (int d = 0; d < 2; d++) begin
      req_a[d] = 1'b0;
      req_b[d] = 1'b0;
      model_dout[d][0] = '0;
      model_dout[d][1] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd", rd[0], 0);
    check("rst_we", we[0], 0);
    check("rst_burstcnt", burstcnt[0], 1);
    check("rst_addr", addr[0], 0);
    check("rst_be", be[0], 0);
    check("rst_acks", {a_ack[0], b_ack[0], a_valid[0], b_valid[0]}, 0);
    check("rst_dout", a_dout[0], 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: single A write, BUSY low; the 32-bit example address truncates to 29 bits.
    t1_addr = 29'(32'h3000_0010);
    a_we = 1'b1; a_addr = t1_addr; a_din = 64'h1122334455667788; a_be = 8'h0F; a_burst = 8'd0;
    req_a[0] = 1'b1;
    expect_op(0, 1'b0, 1'b1, t1_addr, 8'd0);
    @(negedge clk);
    check("t1_we_early", we[0], 0);
    @(negedge clk);
    check("t1_we", we[0], 1);
    check("t1_rd", rd[0], 0);
    check("t1_addr", addr[0], t1_addr);
    check("t1_din", din[0], 64'h1122334455667788);
    check("t1_be", be[0], 8'h0F);
    check("t1_ack_early", a_ack[0], 0);
    @(negedge clk);
    check("t1_we_drop", we[0], 0);
    check("t1_ack", a_ack[0], 1);
    check("t1_b_quiet", {b_ack[0], b_valid[0]}, 0);
    req_a[0] = 1'b0;

    // T2: B read burst 2 stalled for three cycles.
    busy_n = 3;
    rd0 = rd_cnt; be0 = be_bad;
    expect_op(0, 1'b1, 1'b0, 29'h0ABCDE, 8'd2);
    client_op(0, 1'b1, 1'b0, 29'h0ABCDE, 8'd2, 64'h0, 8'h00);
    check("t2_rd_cycles", rd_cnt - rd0, 4);
    check("t2_be_ff", be_bad - be0, 0);
    check("t2_burstcnt", last_burstcnt, 2);
    busy_n = 0;

    // T3 fixed priority: simultaneous requests, A first both times.
    expect_op(0, 1'b0, 1'b1, 29'h0000_0100, 8'd0);
    expect_op(0, 1'b1, 1'b0, 29'h0000_0200, 8'd3);
    fork
      client_op(0, 1'b0, 1'b1, 29'h0000_0100, 8'd0, 64'hAAAA, 8'hFF);
      client_op(0, 1'b1, 1'b0, 29'h0000_0200, 8'd3, 64'h0, 8'h00);
    join
    expect_op(0, 1'b0, 1'b0, 29'h0000_0300, 8'd2);
    expect_op(0, 1'b1, 1'b1, 29'h0000_0400, 8'd0);
    fork
      client_op(0, 1'b0, 1'b0, 29'h0000_0300, 8'd2, 64'h0, 8'h00);
      client_op(0, 1'b1, 1'b1, 29'h0000_0400, 8'd0, 64'hBBBB, 8'h3C);
    join

    // T4: burst clamping.
    expect_op(0, 1'b1, 1'b0, 29'h0012_3450, 8'd0);
    client_op(0, 1'b1, 1'b0, 29'h0012_3450, 8'd0, 64'h0, 8'h00);
    check("t4_burst0", last_burstcnt, 1);
    expect_op(0, 1'b1, 1'b0, 29'h0012_3460, 8'd20);
    client_op(0, 1'b1, 1'b0, 29'h0012_3460, 8'd20, 64'h0, 8'h00);
    check("t4_burst20", last_burstcnt, 8);

    // T6: stray beat while idle leaves douts untouched.
    stray_req++;
    repeat (4) @(negedge clk);
    check("t6_a_dout", a_dout[0], model_dout[0][0]);
    check("t6_b_dout", b_dout[0], model_dout[0][1]);

    // T5: reset after the first of four beats.
    beat_limit = 1;
    b_we = 1'b0; b_addr = 29'h0155_5555; b_burst = 8'd4; b_din = '0; b_be = '0;
    req_b[0] = 1'b1;
    sb.push_back('{0, 1'b1, 1'b1, 1'b0, beat_data(29'h0155_5555, 0)});
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (b_valid[0]) break;
    end
    check("t5_first_beat", b_valid[0], 1);
    #1;
    rst = 1'b1;
    req_b[0] = 1'b0;
    #1;
    check("t5_rst_valid", b_valid[0], 0);
    check("t5_rst_dout", b_dout[0], 0);
    check("t5_rst_rd", rd[0], 0);
    check("t5_rst_addr", addr[0], 0);
    check("t5_rst_burstcnt", burstcnt[0], 1);
    for (int d = 0; d < 2; d++) begin
      model_dout[d][0] = '0;
      model_dout[d][1] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    beat_limit = 64;
    stray_req += 3;
    repeat (10) @(negedge clk);
    check("t5_stray_dout", b_dout[0], model_dout[0][1]);
    check("t5_stray_rd", rd[0], 0);
    expect_op(0, 1'b1, 1'b0, 29'h0000_0ABC, 8'd3);
    client_op(0, 1'b1, 1'b0, 29'h0000_0ABC, 8'd3, 64'h0, 8'h00);

    // T3 round-robin on dut1.
    act = 1;
    repeat (3) @(negedge clk);
    expect_op(1, 1'b0, 1'b1, 29'h0000_1000, 8'd0);
    expect_op(1, 1'b1, 1'b1, 29'h0000_2000, 8'd0);
    fork
      client_op(1, 1'b0, 1'b1, 29'h0000_1000, 8'd0, 64'h1, 8'hFF);
      client_op(1, 1'b1, 1'b1, 29'h0000_2000, 8'd0, 64'h2, 8'hFF);
    join
    expect_op(1, 1'b0, 1'b1, 29'h0000_1008, 8'd0);
    expect_op(1, 1'b1, 1'b0, 29'h0000_2008, 8'd2);
    fork
      client_op(1, 1'b0, 1'b1, 29'h0000_1008, 8'd0, 64'h3, 8'hFF);
      client_op(1, 1'b1, 1'b0, 29'h0000_2008, 8'd2, 64'h0, 8'h00);
    join
    expect_op(1, 1'b0, 1'b1, 29'h0000_1010, 8'd0);
    client_op(1, 1'b0, 1'b1, 29'h0000_1010, 8'd0, 64'h4, 8'hFF);
    expect_op(1, 1'b1, 1'b0, 29'h0000_2010, 8'd2);
    expect_op(1, 1'b0, 1'b1, 29'h0000_1018, 8'd0);
    fork
      client_op(1, 1'b0, 1'b1, 29'h0000_1018, 8'd0, 64'h5, 8'hFF);
      client_op(1, 1'b1, 1'b0, 29'h0000_2010, 8'd2, 64'h0, 8'h00);
    join

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
